key_debounce: RTL and testbench

//  Input-side companion to the LED blink driver: conditions one raw push-button pin into clean

---
 rtl/key_pkg.sv | 20 ++
 rtl/key_sync.sv | 26 ++
 rtl/key_debounce.sv | 130 +++++++++++++
 tb/tb_key_debounce.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the push-button conditioning block: FSM encoding and 50 MHz timing defaults.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } key_fsm_e;

    localparam int DEF_CLK_HZ       = 50_000_000;
    localparam int DEF_DEBOUNCE_CNT = 999_999;
    localparam int DEF_LONG_CNT     = 49_999_999;

    // A terminal value of 0 would otherwise give a zero-width counter.
    function automatic int cnt_width(input int maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for an asynchronous pin; RESET_VAL is the level both flops take in reset.
module key_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_ff1;
    logic r_ff2;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ff1 <= RESET_VAL;
            r_ff2 <= RESET_VAL;
        end else begin
            r_ff1 <= i_d;
            r_ff2 <= r_ff1;
        end
    end

    assign o_q = r_ff2;

endmodule

// File: rtl/key_debounce.sv
// Debounces one raw key pin into a clean level plus press/release pulses.
// Define KEY_LONG_PRESS_EN to build the long-press detector; otherwise long_press is tied low.
module key_debounce
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CNT   = DEF_DEBOUNCE_CNT,
    parameter int LONG_CNT       = DEF_LONG_CNT,
    parameter bit KEY_ACTIVE_LOW = 1'b1
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic long_press
);

    localparam int DB_W = cnt_width(DEBOUNCE_CNT);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CNT);

    key_fsm_e        r_state;
    logic [DB_W-1:0] r_dbCnt;
    logic            w_keySync;
    logic            w_keyS;
    logic            w_pressDone;
    logic            w_releaseDone;

    // Reset loads the released level so a held key must re-debounce afterwards.
    key_sync #(
        .RESET_VAL (logic'(KEY_ACTIVE_LOW))
    ) u_sync (
        .i_clk (sys_clk),
        .i_rst (sys_rst),
        .i_d   (key_in),
        .o_q   (w_keySync)
    );

    assign w_keyS        = KEY_ACTIVE_LOW ? ~w_keySync : w_keySync;
    assign w_pressDone   = (r_state == PRESS_DB)   &&  w_keyS && (r_dbCnt == DB_LAST);
    assign w_releaseDone = (r_state == RELEASE_DB) && !w_keyS && (r_dbCnt == DB_LAST);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= IDLE;
            r_dbCnt     <= '0;
            key_state   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_keyS) begin
                        r_state <= PRESS_DB;
                        r_dbCnt <= '0;
                    end
                end
                PRESS_DB: begin
                    if (!w_keyS) begin
                        r_state <= IDLE;
                    end else if (w_pressDone) begin
                        r_state   <= HELD;
                        key_press <= 1'b1;
                        key_state <= 1'b1;
                    end else begin
                        r_dbCnt <= r_dbCnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!w_keyS) begin
                        r_state <= RELEASE_DB;
                        r_dbCnt <= '0;
                    end
                end
                RELEASE_DB: begin
                    // A short bounce back to pressed resumes the same press.
                    if (w_keyS) begin
                        r_state <= HELD;
                    end else if (w_releaseDone) begin
                        r_state     <= IDLE;
                        key_release <= 1'b1;
                        key_state   <= 1'b0;
                    end else begin
                        r_dbCnt <= r_dbCnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef KEY_LONG_PRESS_EN
    localparam int HOLD_W = cnt_width(LONG_CNT);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CNT);

    logic [HOLD_W-1:0] r_holdCnt;
    logic              r_longFired;

    // Hold time only accumulates while stably held; it freezes during release debounce.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_holdCnt   <= '0;
            r_longFired <= 1'b0;
            long_press  <= 1'b0;
        end else begin
            long_press <= 1'b0;
            if (w_pressDone) begin
                r_holdCnt <= '0;
            end else if ((r_state == HELD) && w_keyS) begin
                if (r_holdCnt == HOLD_LAST) begin
                    if (!r_longFired) begin
                        long_press  <= 1'b1;
                        r_longFired <= 1'b1;
                    end
                end else begin
                    r_holdCnt <= r_holdCnt + 1'b1;
                end
            end
            if (w_releaseDone) begin
                r_longFired <= 1'b0;
            end
        end
    end
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: expected pulses are queued with their edge number when the key is driven.
module tb_key_debounce;

    localparam int DB     = 15;
    localparam int LC     = 63;
    localparam int LAT    = DB + 4;
    localparam int EV_PRESS   = 1;
    localparam int EV_RELEASE = 2;
    localparam int EV_LONG    = 3;
    localparam int EV_SCALE   = 1_000_000;
`ifdef KEY_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic key_in  = 1'b1;
    logic key_state;
    logic key_press;
    logic key_release;
    logic long_press;

    int errors    = 0;
    int checks    = 0;
    int edgeCount = 0;
    int longCount = 0;
    int expQ[$];

    key_debounce #(
        .DEBOUNCE_CNT   (DB),
        .LONG_CNT       (LC),
        .KEY_ACTIVE_LOW (1'b1)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .key_in      (key_in),
        .key_state   (key_state),
        .key_press   (key_press),
        .key_release (key_release),
        .long_press  (long_press)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) edgeCount <= edgeCount + 1;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Events are encoded as kind*EV_SCALE + edge number after which the pulse is visible.
    task automatic scoreEvent(input int kind);
        int exp;
        if (expQ.size() == 0) begin
            checkOutput("unexpected_event_kind", kind, 0);
        end else begin
            exp = expQ.pop_front();
            checkOutput("event_kind_at_edge", kind * EV_SCALE + edgeCount, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (key_press) begin
                checkOutput("press_release_exclusive", int'(key_release), 0);
                scoreEvent(EV_PRESS);
            end
            if (key_release) scoreEvent(EV_RELEASE);
            if (long_press) begin
                longCount++;
                scoreEvent(EV_LONG);
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Called just after a falling edge; the next rising edge is the first to sample the pin.
    task automatic applyStimulus(input bit pressed, input int expectKind);
        key_in = pressed ? 1'b0 : 1'b1;
        if (expectKind != 0) expQ.push_back(expectKind * EV_SCALE + edgeCount + LAT);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int longBase;

        sys_rst = 1'b1;
        key_in  = 1'b1;
        waitCycles(3);
        checkOutput("reset_key_state",   int'(key_state),   0);
        checkOutput("reset_key_press",   int'(key_press),   0);
        checkOutput("reset_key_release", int'(key_release), 0);
        checkOutput("reset_long_press",  int'(long_press),  0);
        sys_rst = 1'b0;
        waitCycles(5);
        checkOutput("idle_key_state", int'(key_state), 0);

        $display("[TB] press then release");
        applyStimulus(1'b1, EV_PRESS);
        waitCycles(LAT - 1);
        checkOutput("press_state_before", int'(key_state), 0);
        waitCycles(1);
        checkOutput("press_state_after", int'(key_state), 1);
        waitCycles(10);
        checkOutput("press_state_held", int'(key_state), 1);
        applyStimulus(1'b0, EV_RELEASE);
        waitCycles(LAT - 1);
        checkOutput("release_state_before", int'(key_state), 1);
        waitCycles(1);
        checkOutput("release_state_after", int'(key_state), 0);
        waitCycles(10);

        $display("[TB] bounce shorter than debounce window");
        applyStimulus(1'b1, 0);
        waitCycles(10);
        applyStimulus(1'b0, 0);
        waitCycles(30);
        checkOutput("bounce_state", int'(key_state), 0);

        $display("[TB] long hold with release glitch");
        longBase = longCount;
        applyStimulus(1'b1, EV_PRESS);
        if (LONG_EN) expQ.push_back(EV_LONG * EV_SCALE + edgeCount + LAT + LC + 1);
        waitCycles(LAT + 100);
        applyStimulus(1'b0, 0);
        waitCycles(5);
        applyStimulus(1'b1, 0);
        waitCycles(40);
        checkOutput("glitch_state_held", int'(key_state), 1);
        checkOutput("long_press_count", longCount - longBase, LONG_EN ? 1 : 0);
        applyStimulus(1'b0, EV_RELEASE);
        waitCycles(LAT + 10);
        checkOutput("long_release_state", int'(key_state), 0);

        $display("[TB] reset during press debounce");
        applyStimulus(1'b1, 0);
        waitCycles(8);
        sys_rst = 1'b1;
        waitCycles(2);
        checkOutput("midreset_key_state",   int'(key_state),   0);
        checkOutput("midreset_key_press",   int'(key_press),   0);
        checkOutput("midreset_key_release", int'(key_release), 0);
        checkOutput("midreset_long_press",  int'(long_press),  0);
        sys_rst = 1'b0;
        expQ.push_back(EV_PRESS * EV_SCALE + edgeCount + LAT);
        waitCycles(LAT + 5);
        checkOutput("after_reset_state", int'(key_state), 1);

        $display("[TB] reset while held");
        sys_rst = 1'b1;
        waitCycles(1);
        checkOutput("held_reset_state", int'(key_state), 0);
        sys_rst = 1'b0;
        expQ.push_back(EV_PRESS * EV_SCALE + edgeCount + LAT);
        waitCycles(LAT + 3);
        checkOutput("held_rearm_state", int'(key_state), 1);
        applyStimulus(1'b0, EV_RELEASE);
        waitCycles(LAT + 5);
        checkOutput("final_state", int'(key_state), 0);

        waitCycles(20);
        checkOutput("pending_events", expQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
